lcd_write_seq: RTL
==================

// Module: lcd_write_seq
// PURPOSE
//  HD44780 character-LCD write sequencer between the processor LCD I/O and the LCD pins.
//  - Runs the power-up init sequence on its own.
//  - Accepts one command/data byte per valid/ready handshake.
//  - Generates setup / EN-pulse / hold / busy-wait timing.
//  - Drives the LCD pins and a packed 32-bit word in the io_lcd layout:
//    [7:0] data, [8] rw, [9] rs, [10] en, [31] on; all other bits 0.
// PARAMETERS
//  T_PWRUP_CYC  750000  cycles waited after reset before the first init write (15 ms at 50 MHz)
//  T_SETUP_CYC  4       rs/data stable before EN rises (>=40 ns)
//  T_EN_CYC     25      EN high width (>=450 ns)
//  T_HOLD_CYC   2       rs/data held after EN falls
//  T_CMD_CYC    2000    busy wait after a normal command or data write (40 us)
//  T_CLR_CYC    82000   busy wait after clear or home (1.64 ms)
// PORTS
//  clk_i        in   1   system clock (CLOCK_50)
//  rst_i        in   1   asynchronous reset, active-high
//  req_valid_i  in   1   write request valid
//  req_ready_o  out  1   sequencer idle; a request is accepted when req_valid_i && req_ready_o
//  req_rs_i     in   1   0 = command, 1 = data
//  req_data_i   in   8   byte to write
//  init_done_o  out  1   init sequence complete (sticky until reset)
//  busy_o       out  1   ~req_ready_o
//  lcd_data_o   out  8   LCD_DATA
//  lcd_rw_o     out  1   LCD_RW, constant 0 (write only)
//  lcd_rs_o     out  1   LCD_RS
//  lcd_en_o     out  1   LCD_EN
//  lcd_on_o     out  1   LCD_ON
//  lcd_o        out  32  packed copy of the pin outputs in the io_lcd layout
// BEHAVIOUR
//  - Clock and reset: one clock domain. All outputs are registered. Asynchronous reset, active-high.
//  - Reset values: every output 0; FSM state = PWRUP; delay counter = 0; init index = 0.
//  - lcd_on_o rises 1 on the first clock edge after reset is released and stays 1.
//  - FSM states: PWRUP -> LOAD -> SETUP -> EN -> HOLD -> WAIT -> (LOAD | IDLE).
//  - PWRUP: count T_PWRUP_CYC cycles, then go to LOAD.
//  - LOAD: capture init ROM[idx] with rs=0; 1 cycle. ROM = 0x38, 0x0C, 0x01, 0x06.
//  - SETUP: drive rs/data, en=0, for T_SETUP_CYC cycles.
//  - EN: en=1 for exactly T_EN_CYC cycles; rs/data unchanged.
//  - HOLD: en=0 for T_HOLD_CYC cycles; rs/data unchanged.
//  - WAIT: count the busy wait, then:
//    - in init with idx<3: idx++, go to LOAD;
//    - after the last init entry: set init_done_o, go to IDLE;
//    - otherwise go to IDLE.
//  - Busy-wait length: T_CLR_CYC when rs=0 and data is 0x01, 0x02 or 0x03; otherwise T_CMD_CYC.
//  - IDLE: req_ready_o=1. On a handshake, register rs/data and enter SETUP on the next cycle.
//  - Handshake: req_ready_o is 0 in every state except IDLE.
//    - While ready is 0, valid is ignored; nothing is queued or dropped silently.
//    - The requester must hold valid and data until the transfer.
//  - Latency: cycles from transfer to ready re-asserting = T_SETUP_CYC + T_EN_CYC + T_HOLD_CYC + wait.
//    Back-to-back transfers are possible exactly when ready returns.
//  - After HOLD, lcd_data_o and lcd_rs_o keep their last value.
//  - Delay counter width = $clog2(max parameter)+1. It loads at each state entry and counts down to 1.
//    A parameter value of 0 is illegal; use an elaboration-time assertion.
//  - Reset mid-operation, including during EN: en, data and ready go to 0 immediately (async).
//    After reset is released, the full PWRUP and init sequence reruns.
// STRUCTURE
//  - Package lcd_pkg:
//    - state enum lcd_state_e;
//    - INIT_ROM constant array and INIT_LEN=4;
//    - bit-position constants LCD_EN_BIT=10, LCD_RS_BIT=9, LCD_RW_BIT=8, LCD_ON_BIT=31;
//    - CLR/HOME opcode constants.
//  - Sub-module lcd_delay_cnt: loadable down-counter with a done pulse. The FSM, ROM and output
//    registers stay in lcd_write_seq.
// TESTING (params: PWRUP=20 SETUP=2 EN=3 HOLD=1 CMD=10 CLR=30)
//  1. Release reset -> after 20 cycles, four writes with rs=0: 0x38, 0x0C, 0x01, 0x06.
//     Each has en=1 for exactly 3 cycles. The gap after 0x01 is 30 wait cycles; the others are 10.
//     init_done_o and req_ready_o rise together at the end.
//  2. After init, transfer rs=1, 0x41 -> after 2 setup cycles, en=1 for 3 cycles with data=0x41, rs=1.
//     req_ready_o is low for 16 cycles.
//  3. Command rs=0, 0x01 -> wait of 30 cycles. Data rs=1, 0x01 -> wait of 10 cycles (not a clear).
//  4. Hold valid high with 0x48 then 0x49 -> exactly two EN pulses, in order, with no duplicate or lost byte.
//     Valid while busy produces no EN pulse.
//  5. Assert rst_i in the 2nd EN cycle -> lcd_en_o=0 and lcd_o=0 in the same cycle (async).
//     After release, lcd_on_o=1 and init reruns from 0x38.
//  6. Every cycle: lcd_o[10:0] == {en, rs, rw, data}, lcd_o[31]==lcd_on_o, lcd_o[30:11]==0, lcd_rw_o==0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SETUP = 3'd2,
    ST_EN    = 3'd3,
    ST_HOLD  = 3'd4,
    ST_WAIT  = 3'd5,
    ST_IDLE  = 3'd6
  } lcd_state_e;

  localparam int INIT_LEN = 32'd4;
  // function set 8-bit/2-line, display on, clear, entry mode increment
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

  localparam int LCD_EN_BIT = 32'd10;
  localparam int LCD_RS_BIT = 32'd9;
  localparam int LCD_RW_BIT = 32'd8;
  localparam int LCD_ON_BIT = 32'd31;

  localparam logic [7:0] CLR_CMD  = 8'h01;
  localparam logic [7:0] HOME_CMD = 8'h02;

  // Home ignores bit 0, so 0x02 and 0x03 both take the long busy wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && ((data == CLR_CMD) || (data[7:1] == HOME_CMD[7:1]));
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter; done is high while the count sits at 1.
module lcd_delay_cnt #(
  parameter int W = 32'd8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Count down from the loaded value and rest at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - W'(1);
    end
  end

  assign done = (cnt_r == W'(1));
  assign zero = (cnt_r == '0);

endmodule

// File: rtl/lcd_param_chk.sv
// Elaboration-time sanity check of the sequencer timing parameters.
module lcd_param_chk #(
  parameter int T_PWRUP_CYC = 32'd1,
  parameter int T_SETUP_CYC = 32'd1,
  parameter int T_EN_CYC    = 32'd1,
  parameter int T_HOLD_CYC  = 32'd1,
  parameter int T_CMD_CYC   = 32'd1,
  parameter int T_CLR_CYC   = 32'd1
) ();

  if ((T_PWRUP_CYC <= 0) || (T_SETUP_CYC <= 0) || (T_EN_CYC <= 0) ||
      (T_HOLD_CYC <= 0) || (T_CMD_CYC <= 0) || (T_CLR_CYC <= 0)) begin : g_bad_param
    $error("lcd_write_seq: every timing parameter must be at least 1");
  end

endmodule

// File: rtl/lcd_write_seq.sv
// HD44780 write sequencer: power-up init, then one command/data byte per
// valid/ready handshake with setup, EN pulse, hold and busy-wait timing.
module lcd_write_seq
  import lcd_pkg::*;
#(
  parameter int T_PWRUP_CYC = 32'd750000,
  parameter int T_SETUP_CYC = 32'd4,
  parameter int T_EN_CYC    = 32'd25,
  parameter int T_HOLD_CYC  = 32'd2,
  parameter int T_CMD_CYC   = 32'd2000,
  parameter int T_CLR_CYC   = 32'd82000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rs_i,
  input  logic [7:0]  req_data_i,
  output logic        init_done_o,
  output logic        busy_o,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rw_o,
  output logic        lcd_rs_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o,
  output logic [31:0] lcd_o
);

  localparam int MAX_CYC = max_int(max_int(max_int(T_PWRUP_CYC, T_SETUP_CYC), max_int(T_EN_CYC, T_HOLD_CYC)),
                                   max_int(T_CMD_CYC, T_CLR_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC) + 32'd1;

  lcd_state_e       state_r;
  logic [1:0]       idx_r;
  logic [7:0]       data_r;
  logic             rs_r;
  logic             en_r;
  logic             on_r;
  logic             ready_r;
  logic             busy_r;
  logic             init_done_r;
  logic             load_s;
  logic [CNT_W-1:0] load_val_s;
  logic             done_s;
  logic             zero_s;
  logic [31:0]      lcd_s;

  lcd_param_chk #(
    .T_PWRUP_CYC(T_PWRUP_CYC), .T_SETUP_CYC(T_SETUP_CYC), .T_EN_CYC(T_EN_CYC),
    .T_HOLD_CYC(T_HOLD_CYC), .T_CMD_CYC(T_CMD_CYC), .T_CLR_CYC(T_CLR_CYC)
  ) u_param_chk ();

  lcd_delay_cnt #(.W(CNT_W)) u_delay_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (load_s),
    .load_val (load_val_s),
    .done     (done_s),
    .zero     (zero_s)
  );

  // Counter reload: each timed state gets its length on the edge that enters it.
  always_comb begin
    load_s     = 1'b0;
    load_val_s = '0;
    case (state_r)
      ST_PWRUP: begin
        load_s     = zero_s;
        load_val_s = CNT_W'(T_PWRUP_CYC);
      end
      ST_LOAD: begin
        load_s     = 1'b1;
        load_val_s = CNT_W'(T_SETUP_CYC);
      end
      ST_SETUP: begin
        load_s     = done_s;
        load_val_s = CNT_W'(T_EN_CYC);
      end
      ST_EN: begin
        load_s     = done_s;
        load_val_s = CNT_W'(T_HOLD_CYC);
      end
      ST_HOLD: begin
        load_s     = done_s;
        load_val_s = is_long_cmd(rs_r, data_r) ? CNT_W'(T_CLR_CYC) : CNT_W'(T_CMD_CYC);
      end
      ST_IDLE: begin
        load_s     = req_valid_i && ready_r;
        load_val_s = CNT_W'(T_SETUP_CYC);
      end
      default: begin
        load_s     = 1'b0;
        load_val_s = '0;
      end
    endcase
  end

  // Sequencer FSM with registered pin and handshake outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_PWRUP;
      idx_r       <= 2'd0;
      data_r      <= 8'h00;
      rs_r        <= 1'b0;
      en_r        <= 1'b0;
      on_r        <= 1'b0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      on_r <= 1'b1;
      case (state_r)
        ST_PWRUP: begin
          busy_r <= 1'b1;
          if (done_s) state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          data_r  <= INIT_ROM[idx_r];
          rs_r    <= 1'b0;
          state_r <= ST_SETUP;
        end
        ST_SETUP: begin
          if (done_s) begin
            en_r    <= 1'b1;
            state_r <= ST_EN;
          end
        end
        ST_EN: begin
          if (done_s) begin
            en_r    <= 1'b0;
            state_r <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (done_s) state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_s) begin
            if (!init_done_r && (idx_r != 2'(INIT_LEN - 1))) begin
              idx_r   <= idx_r + 2'd1;
              state_r <= ST_LOAD;
            end else begin
              init_done_r <= 1'b1;
              ready_r     <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          if (req_valid_i && ready_r) begin
            rs_r    <= req_rs_i;
            data_r  <= req_data_i;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_SETUP;
          end
        end
        default: begin
          state_r <= ST_PWRUP;
        end
      endcase
    end
  end

  // Pack the pin registers into the io_lcd word layout.
  always_comb begin
    lcd_s             = 32'h0000_0000;
    lcd_s[7:0]        = data_r;
    lcd_s[LCD_RW_BIT] = 1'b0;
    lcd_s[LCD_RS_BIT] = rs_r;
    lcd_s[LCD_EN_BIT] = en_r;
    lcd_s[LCD_ON_BIT] = on_r;
  end

  assign req_ready_o = ready_r;
  assign busy_o      = busy_r;
  assign init_done_o = init_done_r;
  assign lcd_data_o  = data_r;
  assign lcd_rw_o    = 1'b0;
  assign lcd_rs_o    = rs_r;
  assign lcd_en_o    = en_r;
  assign lcd_on_o    = on_r;
  assign lcd_o       = lcd_s;

endmodule
